io_bus_uart_responder: RTL and testbench

Responder on the 16-bit external IO bus driven by the CPEN391_Computer bridge (io_address/io_bus_enable/io_rw/io_acknowledge/io_irq). It decodes a 16-byte register window and implements an 8N1 UART with TX and RX FIFOs. It is the slave end of the bridge protocol: it completes each bus cycle with a single acknowledge pulse and raises io_irq on enabled UART events.

---
 rtl/io_bus_uart_responder.sv | 290 +++++++++++++++++++++++++++++
 tb/tb_io_bus_uart_responder.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_uart_responder.sv
// IO-bus slave exposing an 8N1 UART (TX/RX FIFOs, sticky error flags, IRQ)
// through a 16-byte register window; every bus cycle gets exactly one ack.

module io_bus_uart_responder_fifo #(
   parameter int DEPTH = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       i_push,
   input  logic       i_pop,
   input  logic [7:0] i_data,
   output logic [7:0] o_data,
   output logic       o_empty,
   output logic       o_full
);
   localparam int AW = $clog2(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wptr;
   logic [AW-1:0] r_rptr;
   logic [AW:0]   r_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
         r_cnt  <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + 1'b1;
         if (i_pop)  r_rptr <= r_rptr + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_cnt <= r_cnt + 1'b1;
            2'b01:   r_cnt <= r_cnt - 1'b1;
            default: ;
         endcase
      end
   end

   // Storage needs no reset; occupancy is tracked by r_cnt.
   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wptr] <= i_data;
   end

   assign o_data  = r_mem[r_rptr];
   assign o_empty = (r_cnt == '0);
   assign o_full  = (r_cnt == (AW+1)'(DEPTH));
endmodule

module io_bus_uart_responder #(
   parameter logic [15:0] BASE_ADDR     = 16'h0000,
   parameter int          FIFO_DEPTH    = 8,
   parameter logic [15:0] DIVISOR_RESET = 16'd434
) (
   input  logic        clk_clk,
   input  logic        reset_reset_n,
   input  logic [15:0] io_address,
   input  logic        io_bus_enable,
   input  logic [1:0]  io_byte_enable,
   input  logic        io_rw,
   input  logic [15:0] io_write_data,
   output logic [15:0] io_read_data,
   output logic        io_acknowledge,
   output logic        io_irq,
   input  logic        uart_rxd,
   output logic        uart_txd
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_ACK   = 2'd1;
   localparam logic [1:0] S_HOLD  = 2'd2;

   localparam logic [1:0] R_IDLE  = 2'd0;
   localparam logic [1:0] R_START = 2'd1;
   localparam logic [1:0] R_DATA  = 2'd2;
   localparam logic [1:0] R_STOP  = 2'd3;

   logic [1:0]  r_bus_st;
   logic        r_ack;
   logic [15:0] r_rdata;
   logic        r_irq;
   logic [1:0]  r_ctrl;
   logic [15:0] r_div;
   logic        r_rx_ovf;
   logic        r_frm_err;
   logic        r_tx_ovf;

   logic        w_hit, w_acc, w_wr, w_rd;
   logic [2:0]  w_reg;
   logic        w_unused;

   logic        w_tx_wreq, w_tx_push, w_tx_pop, w_tx_empty, w_tx_full;
   logic [7:0]  w_tx_head;
   logic        w_rx_push, w_rx_pop, w_rx_empty, w_rx_full;
   logic [7:0]  w_rx_head;
   logic        w_tx_idle, w_tx_last;
   logic        w_rx_fall, w_rx_done, w_rx_ferr;
   logic [2:0]  w_clr;
   logic [15:0] w_div_new;
   logic [15:0] w_status;
   logic [15:0] w_rd_mux;

   logic        r_tx_busy;
   logic [8:0]  r_tx_sh;
   logic [15:0] r_tx_div;
   logic [15:0] r_tx_cnt;
   logic [3:0]  r_tx_left;
   logic        r_txd;

   logic        r_rx_s1, r_rx_s2, r_rx_s3;
   logic [1:0]  r_rx_st;
   logic [15:0] r_rx_div;
   logic [15:0] r_rx_cnt;
   logic [2:0]  r_rx_bit;
   logic [7:0]  r_rx_sh;

   // Registers are halfword-aligned; the byte address bit carries no meaning.
   assign w_hit    = (io_address[15:4] == BASE_ADDR[15:4]);
   assign w_acc    = (r_bus_st == S_IDLE) && io_bus_enable && w_hit;
   assign w_wr     = w_acc && !io_rw;
   assign w_rd     = w_acc && io_rw;
   assign w_reg    = io_address[3:1];
   assign w_unused = io_address[0];

   assign w_tx_wreq = w_wr && (w_reg == 3'd0) && io_byte_enable[0];
   assign w_tx_push = w_tx_wreq && (!w_tx_full || w_tx_pop);
   assign w_rx_pop  = w_rd && (w_reg == 3'd0) && !w_rx_empty;
   assign w_rx_push = w_rx_done && (!w_rx_full || w_rx_pop);

   io_bus_uart_responder_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk_clk),
      .rst_n   (reset_reset_n),
      .i_push  (w_tx_push),
      .i_pop   (w_tx_pop),
      .i_data  (io_write_data[7:0]),
      .o_data  (w_tx_head),
      .o_empty (w_tx_empty),
      .o_full  (w_tx_full)
   );

   io_bus_uart_responder_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (clk_clk),
      .rst_n   (reset_reset_n),
      .i_push  (w_rx_push),
      .i_pop   (w_rx_pop),
      .i_data  (r_rx_sh),
      .o_data  (w_rx_head),
      .o_empty (w_rx_empty),
      .o_full  (w_rx_full)
   );

   assign w_tx_idle = w_tx_empty && !r_tx_busy;
   assign w_status  = {10'd0, r_tx_ovf, r_frm_err, r_rx_ovf, w_tx_idle, !w_tx_full, !w_rx_empty};
   assign w_clr     = (w_wr && (w_reg == 3'd1) && io_byte_enable[0]) ? io_write_data[5:3] : 3'b000;
   assign w_div_new = {io_byte_enable[1] ? io_write_data[15:8] : r_div[15:8],
                       io_byte_enable[0] ? io_write_data[7:0]  : r_div[7:0]};

   always_comb begin
      w_rd_mux = 16'h0000;
      case (w_reg)
         3'd0:    w_rd_mux = {8'h00, w_rx_empty ? 8'h00 : w_rx_head};
         3'd1:    w_rd_mux = w_status;
         3'd2:    w_rd_mux = {14'd0, r_ctrl};
         3'd3:    w_rd_mux = r_div;
         default: w_rd_mux = 16'h0000;
      endcase
   end

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_bus_st  <= S_IDLE;
         r_ack     <= 1'b0;
         r_rdata   <= 16'h0000;
         r_irq     <= 1'b0;
         r_ctrl    <= 2'b00;
         r_div     <= DIVISOR_RESET;
         r_rx_ovf  <= 1'b0;
         r_frm_err <= 1'b0;
         r_tx_ovf  <= 1'b0;
      end else begin
         r_ack <= w_acc;
         case (r_bus_st)
            S_IDLE:  if (w_acc) r_bus_st <= S_ACK;
            S_ACK:   r_bus_st <= S_HOLD;
            S_HOLD:  if (!io_bus_enable) r_bus_st <= S_IDLE;
            default: r_bus_st <= S_IDLE;
         endcase
         if (w_rd) r_rdata <= w_rd_mux;
         if (w_wr && (w_reg == 3'd2) && io_byte_enable[0]) r_ctrl <= io_write_data[1:0];
         if (w_wr && (w_reg == 3'd3)) r_div <= (w_div_new < 16'd4) ? 16'd4 : w_div_new;
         // New events win over a same-cycle clear.
         r_rx_ovf  <= (r_rx_ovf  & ~w_clr[0]) | (w_rx_done & w_rx_full & ~w_rx_pop);
         r_frm_err <= (r_frm_err & ~w_clr[1]) | w_rx_ferr;
         r_tx_ovf  <= (r_tx_ovf  & ~w_clr[2]) | (w_tx_wreq & w_tx_full & ~w_tx_pop);
         r_irq     <= (r_ctrl[0] & ~w_rx_empty) | (r_ctrl[1] & w_tx_idle);
      end
   end

   // A new frame may load on the last clock of the stop bit, so frames abut.
   assign w_tx_last = r_tx_busy && (r_tx_cnt == 16'd0) && (r_tx_left == 4'd0);
   assign w_tx_pop  = !w_tx_empty && (!r_tx_busy || w_tx_last);

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_tx_busy <= 1'b0;
         r_tx_sh   <= 9'h1FF;
         r_tx_div  <= DIVISOR_RESET;
         r_tx_cnt  <= 16'd0;
         r_tx_left <= 4'd0;
         r_txd     <= 1'b1;
      end else if (w_tx_pop) begin
         r_tx_busy <= 1'b1;
         r_tx_sh   <= {1'b1, w_tx_head};
         r_tx_div  <= r_div;
         r_tx_cnt  <= r_div - 16'd1;
         r_tx_left <= 4'd9;
         r_txd     <= 1'b0;
      end else if (r_tx_busy) begin
         if (r_tx_cnt != 16'd0) begin
            r_tx_cnt <= r_tx_cnt - 16'd1;
         end else if (r_tx_left == 4'd0) begin
            r_tx_busy <= 1'b0;
         end else begin
            r_txd     <= r_tx_sh[0];
            r_tx_sh   <= {1'b1, r_tx_sh[8:1]};
            r_tx_left <= r_tx_left - 4'd1;
            r_tx_cnt  <= r_tx_div - 16'd1;
         end
      end
   end

   assign w_rx_fall = r_rx_s3 & ~r_rx_s2;
   assign w_rx_done = (r_rx_st == R_STOP) && (r_rx_cnt == 16'd0) &&  r_rx_s2;
   assign w_rx_ferr = (r_rx_st == R_STOP) && (r_rx_cnt == 16'd0) && !r_rx_s2;

   // Edge is seen one clock after s2 falls, hence half-2 to land mid start bit.
   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         r_rx_s1  <= 1'b1;
         r_rx_s2  <= 1'b1;
         r_rx_s3  <= 1'b1;
         r_rx_st  <= R_IDLE;
         r_rx_div <= DIVISOR_RESET;
         r_rx_cnt <= 16'd0;
         r_rx_bit <= 3'd0;
         r_rx_sh  <= 8'h00;
      end else begin
         r_rx_s1 <= uart_rxd;
         r_rx_s2 <= r_rx_s1;
         r_rx_s3 <= r_rx_s2;
         case (r_rx_st)
            R_IDLE: begin
               if (w_rx_fall) begin
                  r_rx_div <= r_div;
                  r_rx_cnt <= {1'b0, r_div[15:1]} - 16'd2;
                  r_rx_st  <= R_START;
               end
            end
            R_START: begin
               if (r_rx_cnt != 16'd0) begin
                  r_rx_cnt <= r_rx_cnt - 16'd1;
               end else if (r_rx_s2) begin
                  r_rx_st <= R_IDLE;
               end else begin
                  r_rx_cnt <= r_rx_div - 16'd1;
                  r_rx_bit <= 3'd0;
                  r_rx_st  <= R_DATA;
               end
            end
            R_DATA: begin
               if (r_rx_cnt != 16'd0) begin
                  r_rx_cnt <= r_rx_cnt - 16'd1;
               end else begin
                  r_rx_sh  <= {r_rx_s2, r_rx_sh[7:1]};
                  r_rx_cnt <= r_rx_div - 16'd1;
                  r_rx_bit <= r_rx_bit + 3'd1;
                  if (r_rx_bit == 3'd7) r_rx_st <= R_STOP;
               end
            end
            default: begin
               if (r_rx_cnt != 16'd0) r_rx_cnt <= r_rx_cnt - 16'd1;
               else                   r_rx_st  <= R_IDLE;
            end
         endcase
      end
   end

   assign io_acknowledge = r_ack;
   assign io_read_data   = r_rdata;
   assign io_irq         = r_irq;
   assign uart_txd       = r_txd;
endmodule

// File: tb/tb_io_bus_uart_responder.sv
// Directed bench for io_bus_uart_responder: bus protocol, register map,
// TX waveform, RX framing/errors, FIFO overflow and reset behaviour.
module tb_io_bus_uart_responder;
   localparam int FIFO_DEPTH = 8;

   logic        clk = 1'b0;
   logic        reset_reset_n;
   logic [15:0] io_address;
   logic        io_bus_enable;
   logic [1:0]  io_byte_enable;
   logic        io_rw;
   logic [15:0] io_write_data;
   logic [15:0] io_read_data;
   logic        io_acknowledge;
   logic        io_irq;
   logic        uart_rxd;
   logic        uart_txd;

   int tests = 0;
   int fails = 0;

   io_bus_uart_responder #(
      .BASE_ADDR(16'h0000), .FIFO_DEPTH(FIFO_DEPTH), .DIVISOR_RESET(16'd434)
   ) dut (
      .clk_clk        (clk),
      .reset_reset_n  (reset_reset_n),
      .io_address     (io_address),
      .io_bus_enable  (io_bus_enable),
      .io_byte_enable (io_byte_enable),
      .io_rw          (io_rw),
      .io_write_data  (io_write_data),
      .io_read_data   (io_read_data),
      .io_acknowledge (io_acknowledge),
      .io_irq         (io_irq),
      .uart_rxd       (uart_rxd),
      .uart_txd       (uart_txd)
   );

   always #5 clk = ~clk;

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   // One bus cycle; a missing acknowledge within the bound is a failure.
   task automatic bus_xfer(input logic rw, input logic [15:0] a, input logic [15:0] d,
                           input logic [1:0] b, output logic [15:0] rd);
      int n;
      int acks;
      @(negedge clk);
      io_address = a; io_rw = rw; io_write_data = d; io_byte_enable = b; io_bus_enable = 1'b1;
      acks = 0; n = 0; rd = 16'hxxxx;
      while (acks == 0 && n < 16) begin
         @(negedge clk);
         n++;
         if (io_acknowledge === 1'b1) begin
            acks++;
            rd = io_read_data;
         end
      end
      io_bus_enable = 1'b0;
      tests++;
      if (acks != 1) begin
         fails++;
         $display("FAIL bus_ack addr=%h got %0d acks, need 1", a, acks);
      end
      @(negedge clk);
   endtask

   task automatic wr(input logic [15:0] a, input logic [15:0] d);
      logic [15:0] dummy;
      bus_xfer(1'b0, a, d, 2'b11, dummy);
   endtask

   task automatic rd(input logic [15:0] a, output logic [15:0] d);
      bus_xfer(1'b1, a, 16'h0000, 2'b11, d);
   endtask

   task automatic rx_frame(input logic [7:0] b, input logic stop);
      logic [9:0] f;
      f = {stop, b, 1'b0};
      for (int i = 0; i < 10; i++) begin
         @(negedge clk) uart_rxd = f[i];
         repeat (7) @(negedge clk);
      end
      @(negedge clk) uart_rxd = 1'b1;
      repeat (12) @(negedge clk);
   endtask

   task automatic test_reset;
      logic [15:0] d;
      reset_reset_n = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (io_acknowledge !== 1'b0 || io_read_data !== 16'h0000 || io_irq !== 1'b0 || uart_txd !== 1'b1) begin
         fails++;
         $display("FAIL reset_outputs ack=%b rdata=%h irq=%b txd=%b, need 0 0000 0 1",
                  io_acknowledge, io_read_data, io_irq, uart_txd);
      end
      reset_reset_n = 1'b1;
      repeat (2) @(negedge clk);
      rd(16'h0002, d);
      tests++;
      if (d !== 16'h0006) begin fails++; $display("FAIL reset_status got %h need 0006", d); end
      rd(16'h0006, d);
      tests++;
      if (d !== 16'd434) begin fails++; $display("FAIL reset_divisor got %h need %h", d, 16'd434); end
      rd(16'h0004, d);
      tests++;
      if (d !== 16'h0000) begin fails++; $display("FAIL reset_control got %h need 0000", d); end
   endtask

   task automatic test_regs;
      logic [15:0] d;
      wr(16'h0006, 16'h0001);
      rd(16'h0006, d);
      tests++;
      if (d !== 16'h0004) begin fails++; $display("FAIL div_clamp got %h need 0004", d); end
      bus_xfer(1'b0, 16'h0006, 16'hAB00, 2'b10, d);
      rd(16'h0006, d);
      tests++;
      if (d !== 16'hAB04) begin fails++; $display("FAIL div_byte_en got %h need AB04", d); end
      wr(16'h0006, 16'h0008);
      rd(16'h0006, d);
      tests++;
      if (d !== 16'h0008) begin fails++; $display("FAIL div_write got %h need 0008", d); end
      wr(16'h0008, 16'h1234);
      rd(16'h0008, d);
      tests++;
      if (d !== 16'h0000) begin fails++; $display("FAIL reserved_read got %h need 0000", d); end
      wr(16'h0004, 16'h0002);
      tests++;
      if (io_irq !== 1'b1) begin fails++; $display("FAIL irq_tx_idle got %b need 1", io_irq); end
      wr(16'h0004, 16'h0000);
      tests++;
      if (io_irq !== 1'b0) begin fails++; $display("FAIL irq_disabled got %b need 0", io_irq); end
   endtask

   task automatic test_tx;
      logic [15:0] d;
      logic [9:0]  f;
      int          bad;
      f = {1'b1, 8'h55, 1'b0};
      bad = 0;
      wr(16'h0000, 16'h0055);
      for (int j = 0; j < 80; j++) begin
         if (uart_txd !== f[j/8]) begin
            if (bad == 0) $display("FAIL tx_wave clk %0d txd=%b need %b", j, uart_txd, f[j/8]);
            bad++;
         end
         @(negedge clk);
      end
      tests++;
      if (bad != 0) fails++;
      rd(16'h0002, d);
      tests++;
      if (d !== 16'h0006 || uart_txd !== 1'b1) begin
         fails++;
         $display("FAIL tx_done status=%h txd=%b need 0006 1", d, uart_txd);
      end
   endtask

   task automatic test_rx;
      logic [15:0] d;
      wr(16'h0004, 16'h0001);
      rx_frame(8'hA3, 1'b1);
      tests++;
      if (io_irq !== 1'b1) begin fails++; $display("FAIL rx_irq_rise got %b need 1", io_irq); end
      rd(16'h0000, d);
      tests++;
      if (d !== 16'h00A3) begin fails++; $display("FAIL rx_data got %h need 00A3", d); end
      tests++;
      if (io_irq !== 1'b0) begin fails++; $display("FAIL rx_irq_fall got %b need 0", io_irq); end
      rd(16'h0000, d);
      tests++;
      if (d !== 16'h0000) begin fails++; $display("FAIL rx_empty_read got %h need 0000", d); end
      wr(16'h0004, 16'h0000);
   endtask

   task automatic test_tx_overflow;
      logic [15:0] d;
      wr(16'h0000, 16'h0011);
      for (int i = 0; i < FIFO_DEPTH + 1; i++) wr(16'h0000, 16'(i + 16'h20));
      rd(16'h0002, d);
      tests++;
      if (d !== 16'h0020) begin fails++; $display("FAIL tx_ovf_set got %h need 0020", d); end
      wr(16'h0002, 16'h0020);
      rd(16'h0002, d);
      tests++;
      if (d !== 16'h0000) begin fails++; $display("FAIL tx_ovf_clear got %h need 0000", d); end
      repeat (800) @(negedge clk);
      rd(16'h0002, d);
      tests++;
      if (d !== 16'h0006) begin fails++; $display("FAIL tx_drain got %h need 0006", d); end
   endtask

   task automatic test_frame_err;
      logic [15:0] d;
      rx_frame(8'h55, 1'b0);
      rd(16'h0002, d);
      tests++;
      if (d !== 16'h0016) begin fails++; $display("FAIL frame_err got %h need 0016", d); end
      wr(16'h0002, 16'h0038);
      rd(16'h0002, d);
      tests++;
      if (d !== 16'h0006) begin fails++; $display("FAIL frame_err_clear got %h need 0006", d); end
   endtask

   task automatic test_glitch;
      logic [15:0] d;
      @(negedge clk) uart_rxd = 1'b0;
      repeat (3) @(negedge clk);
      uart_rxd = 1'b1;
      repeat (100) @(negedge clk);
      rd(16'h0002, d);
      tests++;
      if (d !== 16'h0006) begin fails++; $display("FAIL glitch got %h need 0006", d); end
   endtask

   task automatic test_long_hold;
      logic [15:0] d;
      logic [15:0] cap;
      int          acks;
      rx_frame(8'h5A, 1'b1);
      rx_frame(8'h3C, 1'b1);
      @(negedge clk);
      io_address = 16'h0000; io_rw = 1'b1; io_byte_enable = 2'b11; io_bus_enable = 1'b1;
      acks = 0; cap = 16'hxxxx;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (io_acknowledge === 1'b1) begin acks++; cap = io_read_data; end
      end
      io_bus_enable = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (acks != 1 || cap !== 16'h005A) begin
         fails++;
         $display("FAIL long_hold acks=%0d data=%h need 1 005A", acks, cap);
      end
      rd(16'h0002, d);
      tests++;
      if (d !== 16'h0007) begin fails++; $display("FAIL single_pop status=%h need 0007", d); end
      rd(16'h0000, d);
      tests++;
      if (d !== 16'h003C) begin fails++; $display("FAIL second_byte got %h need 003C", d); end
      wr(16'h0004, 16'h0000);
      tests++;
      if (io_read_data !== 16'h003C) begin
         fails++;
         $display("FAIL rdata_hold got %h need 003C", io_read_data);
      end
   endtask

   task automatic test_miss;
      int acks;
      @(negedge clk);
      io_address = 16'h0010; io_rw = 1'b1; io_byte_enable = 2'b11; io_bus_enable = 1'b1;
      acks = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (io_acknowledge === 1'b1) acks++;
      end
      io_bus_enable = 1'b0;
      repeat (2) @(negedge clk);
      tests++;
      if (acks != 0 || io_read_data !== 16'h003C) begin
         fails++;
         $display("FAIL addr_miss acks=%0d rdata=%h need 0 003C", acks, io_read_data);
      end
   endtask

   task automatic test_reset_midframe;
      logic [15:0] d;
      wr(16'h0000, 16'h0000);
      repeat (20) @(negedge clk);
      tests++;
      if (uart_txd !== 1'b0) begin fails++; $display("FAIL midframe_low got %b need 0", uart_txd); end
      #2 reset_reset_n = 1'b0;
      #1;
      tests++;
      if (uart_txd !== 1'b1 || io_read_data !== 16'h0000) begin
         fails++;
         $display("FAIL reset_abort txd=%b rdata=%h need 1 0000", uart_txd, io_read_data);
      end
      @(negedge clk) reset_reset_n = 1'b1;
      @(negedge clk);
      rd(16'h0002, d);
      tests++;
      if (d !== 16'h0006) begin fails++; $display("FAIL reset_status2 got %h need 0006", d); end
      rd(16'h0006, d);
      tests++;
      if (d !== 16'd434) begin fails++; $display("FAIL reset_div2 got %h need %h", d, 16'd434); end
   endtask

   initial begin
      reset_reset_n  = 1'b0;
      io_address     = 16'h0000;
      io_bus_enable  = 1'b0;
      io_byte_enable = 2'b00;
      io_rw          = 1'b0;
      io_write_data  = 16'h0000;
      uart_rxd       = 1'b1;
      test_reset();
      test_regs();
      test_tx();
      test_rx();
      test_tx_overflow();
      test_frame_err();
      test_glitch();
      test_long_hold();
      test_miss();
      test_reset_midframe();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
